// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the TDC thermometer encoder.
package tdc_pkg;

  localparam int TDC_UNARY_W_DEFAULT = 255;
  localparam int STATS_CNT_W         = 16;

  function automatic int tdc_bin_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/tdc_prio_enc.sv
// Highest-set-bit encoder over the edge vector: code = index + 1, 0 when empty.
// The vector is split into two halves; the upper half always takes precedence.
module tdc_prio_enc
  import tdc_pkg::*;
#(
  parameter int  UNARY_W = TDC_UNARY_W_DEFAULT,
  localparam int BIN_W   = tdc_bin_w(UNARY_W)
) (
  input  logic [UNARY_W-1:0] e_i,
  output logic [BIN_W-1:0]   code_o
);

  localparam int LO_W = UNARY_W / 2;

  logic [BIN_W-1:0] lo_code;
  logic [BIN_W-1:0] hi_code;
  logic             hi_any;

  always_comb begin
    lo_code = '0;
    hi_code = '0;
    hi_any  = 1'b0;
    for (int k = 0; k < LO_W; k++) begin
      if (e_i[k]) lo_code = BIN_W'(k + 1);
    end
    for (int k = LO_W; k < UNARY_W; k++) begin
      if (e_i[k]) begin
        hi_code = BIN_W'(k + 1);
        hi_any  = 1'b1;
      end
    end
    code_o = hi_any ? hi_code : lo_code;
  end

endmodule

// File: rtl/tdc_therm_encoder.sv
// Pipelined thermometer-to-binary encoder: capture, bubble-suppressed edge detect, priority encode.
// Optional bubble statistics counter enabled by defining TDC_ENC_STATS_EN.
module tdc_therm_encoder
  import tdc_pkg::*;
#(
  parameter int  UNARY_W = TDC_UNARY_W_DEFAULT,
  localparam int BIN_W   = tdc_bin_w(UNARY_W)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sample_valid,
  input  logic [UNARY_W-1:0]     therm_in,
`ifdef TDC_ENC_STATS_EN
  input  logic                   stats_clr,
  output logic [STATS_CNT_W-1:0] bubble_cnt,
`endif
  output logic [BIN_W-1:0]       code,
  output logic                   code_valid,
  output logic                   underflow,
  output logic                   overflow,
  output logic                   bubble_err
);

  // A tap is an edge only if the next two taps are clear, hiding single-zero bubbles.
  function automatic logic [UNARY_W-1:0] edge_vec(input logic [UNARY_W-1:0] t);
    logic [UNARY_W-1:0] e;
    for (int k = 0; k < UNARY_W - 2; k++) begin
      e[k] = t[k] & ~t[k+1] & ~t[k+2];
    end
    e[UNARY_W-2] = t[UNARY_W-2] & ~t[UNARY_W-1];
    e[UNARY_W-1] = t[UNARY_W-1];
    return e;
  endfunction

  function automatic logic two_or_more(input logic [UNARY_W-1:0] v);
    logic any;
    logic multi;
    any   = 1'b0;
    multi = 1'b0;
    for (int k = 0; k < UNARY_W; k++) begin
      multi = multi | (any & v[k]);
      any   = any | v[k];
    end
    return multi;
  endfunction

  logic [UNARY_W-1:0] t_p0_q;
  logic               vld_p0_q;
  logic [UNARY_W-1:0] e_p1_d;
  logic [UNARY_W-1:0] e_p1_q;
  logic               multi_p1_d;
  logic               multi_p1_q;
  logic               vld_p1_q;
  logic [BIN_W-1:0]   code_p2_d;
  logic [BIN_W-1:0]   code_p2_q;
  logic               vld_p2_q;
  logic               uf_p2_q;
  logic               of_p2_q;
  logic               be_p2_q;

  // S0: capture
  always_ff @(posedge clk) begin
    if (sample_valid) t_p0_q <= therm_in;
  end

  // S1: edge detect
  assign e_p1_d     = edge_vec(t_p0_q);
  assign multi_p1_d = two_or_more(e_p1_d);

  always_ff @(posedge clk) begin
    e_p1_q     <= e_p1_d;
    multi_p1_q <= multi_p1_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else begin
      vld_p0_q <= sample_valid;
      vld_p1_q <= vld_p0_q;
    end
  end

  // S2: priority encode; results hold between valid strobes
  tdc_prio_enc #(
    .UNARY_W(UNARY_W)
  ) u_prio_enc (
    .e_i   (e_p1_q),
    .code_o(code_p2_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      code_p2_q <= '0;
      uf_p2_q   <= 1'b0;
      of_p2_q   <= 1'b0;
      be_p2_q   <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        code_p2_q <= code_p2_d;
        uf_p2_q   <= ~|e_p1_q;
        of_p2_q   <= e_p1_q[UNARY_W-1];
        be_p2_q   <= multi_p1_q;
      end
    end
  end

  assign code       = code_p2_q;
  assign code_valid = vld_p2_q;
  assign underflow  = uf_p2_q;
  assign overflow   = of_p2_q;
  assign bubble_err = be_p2_q;

`ifdef TDC_ENC_STATS_EN
  function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] c);
    return (c == '1) ? c : c + STATS_CNT_W'(1);
  endfunction

  logic [STATS_CNT_W-1:0] cnt_d;
  logic [STATS_CNT_W-1:0] cnt_q;

  assign cnt_d = (vld_p2_q && be_p2_q) ? sat_inc(cnt_q) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_tdc_therm_encoder.sv
// Self-checking bench for tdc_therm_encoder: directed vector table, reset/stats sequences, random vs reference model.
module tb_tdc_therm_encoder;

  localparam int W  = 255;
  localparam int BW = 8;

  typedef struct {
    logic          v;
    logic [BW-1:0] code;
    logic          uf;
    logic          of;
    logic          be;
  } exp_t;

  typedef struct {
    logic          sv;
    logic [W-1:0]  th;
    logic [BW-1:0] code;
    logic          uf;
    logic          of;
    logic          be;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  therm_in = '0;
  logic [BW-1:0] code;
  logic          code_valid;
  logic          underflow;
  logic          overflow;
  logic          bubble_err;
`ifdef TDC_ENC_STATS_EN
  logic          stats_clr = 1'b0;
  logic [15:0]   bubble_cnt;
  logic [15:0]   exp_cnt = '0;
`endif
  logic          clr_v = 1'b0;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t pipe[$];
  exp_t held;

  always #5 clk = ~clk;

  tdc_therm_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .therm_in    (therm_in),
`ifdef TDC_ENC_STATS_EN
    .stats_clr   (stats_clr),
    .bubble_cnt  (bubble_cnt),
`endif
    .code        (code),
    .code_valid  (code_valid),
    .underflow   (underflow),
    .overflow    (overflow),
    .bubble_err  (bubble_err)
  );

  function automatic logic [W-1:0] rng(input int lo, input int hi);
    logic [W-1:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Reference: list every tap that is set with the (up to two) taps above it clear;
  // the last such tap is the winning edge, more than one listed means a bubble.
  function automatic exp_t ref_model(input logic [W-1:0] t);
    exp_t r;
    int   edges[$];
    bit   clean;
    for (int k = 0; k < W; k++) begin
      clean = t[k];
      for (int j = 1; j <= 2; j++) begin
        if (k + j < W && t[k+j]) clean = 1'b0;
      end
      if (clean) edges.push_back(k);
    end
    r.v    = 1'b1;
    r.code = (edges.size() == 0) ? '0 : BW'(edges[$] + 1);
    r.uf   = (edges.size() == 0);
    r.of   = (r.code == BW'(W));
    r.be   = (edges.size() > 1);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t r;
    r = '{1'b0, '0, 1'b0, 1'b0, 1'b0};
    return r;
  endfunction

  // One clock: check outputs for the sample issued three calls ago, then drive this cycle.
  task automatic cycle(input logic r, input logic sv, input logic [W-1:0] th, input exp_t ex);
    exp_t e;
    @(negedge clk);
    cyc++;
    e = (pipe.size() > 0) ? pipe.pop_front() : idle_exp();
    if (e.v) held = e;
    chk("code_valid", 32'(code_valid), 32'(e.v));
    chk("code",       32'(code),       32'(held.code));
    chk("underflow",  32'(underflow),  32'(held.uf));
    chk("overflow",   32'(overflow),   32'(held.of));
    chk("bubble_err", 32'(bubble_err), 32'(held.be));
`ifdef TDC_ENC_STATS_EN
    chk("bubble_cnt", 32'(bubble_cnt), 32'(exp_cnt));
    if (r || clr_v)                          exp_cnt = '0;
    else if (e.v && e.be && exp_cnt != '1)   exp_cnt = exp_cnt + 16'd1;
    stats_clr = clr_v;
`endif
    rst          = r;
    sample_valid = sv;
    therm_in     = th;
    if (r) begin
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back(idle_exp());
      held = idle_exp();
    end else begin
      ex.v = sv;
      pipe.push_back(ex);
    end
  endtask

  vec_t vec[16];
  int   nvec;

  initial begin
    logic [W-1:0] th;
    exp_t         ex;
    int           n;

    vec[0]  = '{1'b1, rng(0, 99),                 8'd100, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, '0,                         8'd0,   1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, rng(0, 254),                8'd255, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{1'b1, rng(0, 99) | rng(101, 101), 8'd102, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{1'b1, rng(0, 99) | rng(102, 102), 8'd103, 1'b0, 1'b0, 1'b1};
    vec[5]  = '{1'b1, rng(0, 9),                  8'd10,  1'b0, 1'b0, 1'b0};
    vec[6]  = '{1'b1, rng(0, 19),                 8'd20,  1'b0, 1'b0, 1'b0};
    vec[7]  = '{1'b1, rng(0, 29),                 8'd30,  1'b0, 1'b0, 1'b0};
    vec[8]  = '{1'b0, rng(0, 5),                  8'd0,   1'b0, 1'b0, 1'b0};
    vec[9]  = '{1'b1, rng(0, 39),                 8'd40,  1'b0, 1'b0, 1'b0};
    vec[10] = '{1'b1, rng(0, 0),                  8'd1,   1'b0, 1'b0, 1'b0};
    vec[11] = '{1'b1, rng(254, 254),              8'd255, 1'b0, 1'b1, 1'b0};
    vec[12] = '{1'b1, rng(0, 253),                8'd254, 1'b0, 1'b0, 1'b0};
    vec[13] = '{1'b1, rng(0, 24) | rng(26, 49),   8'd50,  1'b0, 1'b0, 1'b0};
    vec[14] = '{1'b1, rng(0, 49) | rng(60, 60),   8'd61,  1'b0, 1'b0, 1'b1};
    vec[15] = '{1'b1, rng(0, 1) | rng(254, 254),  8'd255, 1'b0, 1'b1, 1'b1};
    nvec = 16;

    for (int i = 0; i < 3; i++) pipe.push_back(idle_exp());
    held = idle_exp();

    cycle(1'b1, 1'b0, '0, idle_exp());
    cycle(1'b1, 1'b0, '0, idle_exp());

    for (int i = 0; i < nvec; i++) begin
      ex = '{1'b1, vec[i].code, vec[i].uf, vec[i].of, vec[i].be};
      cycle(1'b0, vec[i].sv, vec[i].th, ex);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, idle_exp());

    // Reset with two samples in flight: both are dropped and outputs return to zero.
    cycle(1'b0, 1'b1, rng(0, 70), ref_model(rng(0, 70)));
    cycle(1'b0, 1'b1, rng(0, 80), ref_model(rng(0, 80)));
    cycle(1'b1, 1'b1, rng(0, 90), idle_exp());
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, idle_exp());

`ifdef TDC_ENC_STATS_EN
    // Four bubble samples; clear coincides with the fourth strobe.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, vec[14].th, ref_model(vec[14].th));
    cycle(1'b0, 1'b0, '0, idle_exp());
    cycle(1'b0, 1'b0, '0, idle_exp());
    clr_v = 1'b1;
    cycle(1'b0, 1'b0, '0, idle_exp());
    clr_v = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, idle_exp());
    // Drive the counter into saturation and beyond.
    for (int i = 0; i < 65540; i++) cycle(1'b0, 1'b1, vec[4].th, ref_model(vec[4].th));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, idle_exp());
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int w = 0; w < W; w++) th[w] = 1'($urandom);
      end else begin
        n  = $urandom_range(0, W);
        th = (n == 0) ? '0 : rng(0, n - 1);
        for (int f = $urandom_range(0, 3); f > 0; f--) begin
          n     = $urandom_range(0, W - 1);
          th[n] = ~th[n];
        end
      end
      cycle(($urandom_range(0, 60) == 0), 1'($urandom_range(0, 3) != 0), th, ref_model(th));
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, idle_exp());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
